// File: rtl/alu_cmd_sequencer_if.sv
// Stream, ALU-operand and status signals of the ALU command sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface alu_cmd_sequencer_if #(
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic [3:0]       in_data;
  logic             in_ready;
  logic [3:0]       alu_inA;
  logic [3:0]       alu_inB;
  logic [1:0]       alu_inC;
  logic [1:0]       alu_op;
  logic [3:0]       alu_ans;
  logic             out_valid;
  logic [3:0]       out_data;
  logic             out_ready;
  logic             busy;
  logic [CNT_W-1:0] cmd_count;

  modport master (
    output in_valid, in_data, alu_ans, out_ready,
    input  in_ready, alu_inA, alu_inB, alu_inC, alu_op,
    input  out_valid, out_data, busy, cmd_count
  );

  modport slave (
    input  in_valid, in_data, alu_ans, out_ready,
    output in_ready, alu_inA, alu_inB, alu_inC, alu_op,
    output out_valid, out_data, busy, cmd_count
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for a 4-bit combinational ALU: collects header/A/B nibbles,
// holds the operands for SETTLE cycles, captures ans and hands it downstream.
module alu_cmd_sequencer #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 8
) (
  input logic                 clk,
  input logic                 reset,
  alu_cmd_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_GETA = 3'd1,
    S_GETB = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  state_e           state_q, state_d;
  logic             in_ready_c, busy_c, in_xfer;

  logic [3:0]       hdr_q, hdr_d;
  logic [3:0]       a_q, a_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       inc_q, inc_d;
  logic [3:0]       ina_q, ina_d;
  logic [3:0]       inb_q, inb_d;
  logic [3:0]       settle_q, settle_d;
  logic [3:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign in_xfer = bus.in_valid && in_ready_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_HDR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HDR:   if (in_xfer) state_d = S_GETA;
      S_GETA:  if (in_xfer) state_d = S_GETB;
      S_GETB:  if (in_xfer) state_d = S_EXEC;
      S_EXEC:  if (settle_q == 4'd0) state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_HDR;
      default: state_d = S_HDR;
    endcase
  end

  always_comb begin
    in_ready_c = 1'b0;
    busy_c     = 1'b1;
    unique case (state_q)
      S_HDR: begin
        in_ready_c = 1'b1;
        busy_c     = 1'b0;
      end
      S_GETA, S_GETB: in_ready_c = 1'b1;
      default:        in_ready_c = 1'b0;
    endcase
  end

  // Datapath next-state: each register only moves on its own state's event.
  always_comb begin
    hdr_d       = hdr_q;
    a_d         = a_q;
    op_d        = op_q;
    inc_d       = inc_q;
    ina_d       = ina_q;
    inb_d       = inb_q;
    settle_d    = settle_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      S_HDR:  if (in_xfer) hdr_d = bus.in_data;
      S_GETA: if (in_xfer) a_d = bus.in_data;
      S_GETB: begin
        if (in_xfer) begin
          op_d     = hdr_q[3:2];
          inc_d    = hdr_q[1:0];
          ina_d    = a_q;
          inb_d    = bus.in_data;
          settle_d = SETTLE_LD;
        end
      end
      S_EXEC: begin
        if (settle_q == 4'd0) begin
          out_data_d  = bus.alu_ans;
          out_valid_d = 1'b1;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_q       <= '0;
      a_q         <= '0;
      op_q        <= '0;
      inc_q       <= '0;
      ina_q       <= '0;
      inb_q       <= '0;
      settle_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      hdr_q       <= hdr_d;
      a_q         <= a_d;
      op_q        <= op_d;
      inc_q       <= inc_d;
      ina_q       <= ina_d;
      inb_q       <= inb_d;
      settle_q    <= settle_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = busy_c;
  assign bus.alu_op    = op_q;
  assign bus.alu_inC   = inc_q;
  assign bus.alu_inA   = ina_q;
  assign bus.alu_inB   = inb_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cmd_count = cnt_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer; the ALU is stubbed as (inA + inB) mod 16.
module tb_alu_cmd_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.CNT_W(8)) b1 ();
  alu_cmd_sequencer_if #(.CNT_W(2)) b3 ();

  assign b1.alu_ans = b1.alu_inA + b1.alu_inB;
  assign b3.alu_ans = b3.alu_inA + b3.alu_inB;

  alu_cmd_sequencer #(.SETTLE(1), .CNT_W(8)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  alu_cmd_sequencer #(.SETTLE(3), .CNT_W(2)) dut3 (.clk(clk), .reset(reset), .bus(b3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [3:0] h, input logic [3:0] a, input logic [3:0] bb);
    b1.in_valid = 1'b1; b1.in_data = h;  tick();
    b1.in_data  = a;    tick();
    b1.in_data  = bb;   tick();
    b1.in_valid = 1'b0;
  endtask

  task automatic send3(input logic [3:0] h, input logic [3:0] a, input logic [3:0] bb);
    b3.in_valid = 1'b1; b3.in_data = h;  tick();
    b3.in_data  = a;    tick();
    b3.in_data  = bb;   tick();
    b3.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (b1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0d want 0", b1.busy); end
    checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0d want 1", b1.in_ready); end
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0d want 0", b1.out_valid); end
    checks++; if (b1.cmd_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", b1.cmd_count); end
    checks++; if ({b1.alu_op, b1.alu_inC, b1.alu_inA, b1.alu_inB, b1.out_data} !== 16'h0) begin errors++; $display("FAIL reset_regs: got %h want 0000", {b1.alu_op, b1.alu_inC, b1.alu_inA, b1.alu_inB, b1.out_data}); end
    checks++; if (b3.busy !== 1'b0 || b3.cmd_count !== 2'd0) begin errors++; $display("FAIL reset_dut3: got busy=%0d cnt=%0d want 0 0", b3.busy, b3.cmd_count); end
  endtask

  task automatic test_basic();
    b1.out_ready = 1'b1;
    send1(4'b0110, 4'h3, 4'h5);
    checks++; if (b1.alu_op !== 2'd1) begin errors++; $display("FAIL basic_op: got %0d want 1", b1.alu_op); end
    checks++; if (b1.alu_inC !== 2'd2) begin errors++; $display("FAIL basic_inC: got %0d want 2", b1.alu_inC); end
    checks++; if (b1.alu_inA !== 4'h3) begin errors++; $display("FAIL basic_inA: got %0h want 3", b1.alu_inA); end
    checks++; if (b1.alu_inB !== 4'h5) begin errors++; $display("FAIL basic_inB: got %0h want 5", b1.alu_inB); end
    checks++; if (b1.out_valid !== 1'b0 || b1.busy !== 1'b1 || b1.in_ready !== 1'b0) begin errors++; $display("FAIL basic_exec: got ov=%0d busy=%0d rdy=%0d want 0 1 0", b1.out_valid, b1.busy, b1.in_ready); end
    tick();
    checks++; if (b1.out_valid !== 1'b1 || b1.out_data !== 4'h8) begin errors++; $display("FAIL basic_result: got ov=%0d data=%0h want 1 8", b1.out_valid, b1.out_data); end
    checks++; if (b1.cmd_count !== 8'd0) begin errors++; $display("FAIL basic_count_pre: got %0d want 0", b1.cmd_count); end
    tick();
    checks++; if (b1.cmd_count !== 8'd1 || b1.out_valid !== 1'b0 || b1.busy !== 1'b0) begin errors++; $display("FAIL basic_done: got cnt=%0d ov=%0d busy=%0d want 1 0 0", b1.cmd_count, b1.out_valid, b1.busy); end
    b1.out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    b1.out_ready = 1'b0;
    send1(4'h0, 4'hF, 4'h2);
    b1.in_valid = 1'b1; b1.in_data = 4'hA;
    checks++; if (b1.in_ready !== 1'b0) begin errors++; $display("FAIL ovf_exec_ready: got %0d want 0", b1.in_ready); end
    tick();
    checks++; if (b1.out_valid !== 1'b1 || b1.out_data !== 4'h1) begin errors++; $display("FAIL ovf_result: got ov=%0d data=%0h want 1 1", b1.out_valid, b1.out_data); end
    checks++; if (b1.in_ready !== 1'b0) begin errors++; $display("FAIL ovf_done_ready: got %0d want 0", b1.in_ready); end
    tick();
    checks++; if (b1.busy !== 1'b1 || b1.out_valid !== 1'b1 || b1.out_data !== 4'h1) begin errors++; $display("FAIL ovf_hold: got busy=%0d ov=%0d data=%0h want 1 1 1", b1.busy, b1.out_valid, b1.out_data); end
    b1.in_valid = 1'b0; b1.out_ready = 1'b1;
    tick();
    checks++; if (b1.cmd_count !== 8'd2 || b1.busy !== 1'b0) begin errors++; $display("FAIL ovf_release: got cnt=%0d busy=%0d want 2 0", b1.cmd_count, b1.busy); end
    checks++; if (b1.alu_inA !== 4'hF || b1.alu_inB !== 4'h2) begin errors++; $display("FAIL ovf_operands_held: got A=%0h B=%0h want f 2", b1.alu_inA, b1.alu_inB); end
    b1.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    b1.out_ready = 1'b0;
    send1(4'b0110, 4'h3, 4'h5);
    tick();
    checks++; if (b1.out_valid !== 1'b1 || b1.out_data !== 4'h8) begin errors++; $display("FAIL bp_result: got ov=%0d data=%0h want 1 8", b1.out_valid, b1.out_data); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (b1.out_valid !== 1'b1 || b1.out_data !== 4'h8 || b1.busy !== 1'b1 || b1.in_ready !== 1'b0 || b1.cmd_count !== 8'd2) begin
        errors++;
        $display("FAIL bp_hold_%0d: got ov=%0d data=%0h busy=%0d rdy=%0d cnt=%0d want 1 8 1 0 2", i, b1.out_valid, b1.out_data, b1.busy, b1.in_ready, b1.cmd_count);
      end
    end
    b1.out_ready = 1'b1;
    tick();
    checks++; if (b1.cmd_count !== 8'd3 || b1.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got cnt=%0d ov=%0d want 3 0", b1.cmd_count, b1.out_valid); end
    b1.out_ready = 1'b0;
    tick();
    checks++; if (b1.cmd_count !== 8'd3 || b1.busy !== 1'b0) begin errors++; $display("FAIL bp_single_inc: got cnt=%0d busy=%0d want 3 0", b1.cmd_count, b1.busy); end
  endtask

  task automatic test_bubbles();
    logic       vld [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] dat [6] = '{4'h9, 4'hF, 4'hF, 4'h4, 4'hF, 4'h7};
    b1.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      b1.in_valid = vld[i];
      b1.in_data  = dat[i];
      checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL bub_ready_%0d: got %0d want 1", i, b1.in_ready); end
      tick();
    end
    b1.in_valid = 1'b0;
    checks++; if (b1.alu_op !== 2'd2 || b1.alu_inC !== 2'd1) begin errors++; $display("FAIL bub_hdr: got op=%0d C=%0d want 2 1", b1.alu_op, b1.alu_inC); end
    checks++; if (b1.alu_inA !== 4'h4 || b1.alu_inB !== 4'h7) begin errors++; $display("FAIL bub_ab: got A=%0h B=%0h want 4 7", b1.alu_inA, b1.alu_inB); end
    checks++; if (b1.in_ready !== 1'b0) begin errors++; $display("FAIL bub_exec_ready: got %0d want 0", b1.in_ready); end
    tick();
    checks++; if (b1.out_valid !== 1'b1 || b1.out_data !== 4'hB) begin errors++; $display("FAIL bub_result: got ov=%0d data=%0h want 1 b", b1.out_valid, b1.out_data); end
    b1.out_ready = 1'b1;
    tick();
    checks++; if (b1.cmd_count !== 8'd4) begin errors++; $display("FAIL bub_count: got %0d want 4", b1.cmd_count); end
    b1.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    b1.in_valid = 1'b1; b1.in_data = 4'hC; tick();
    b1.in_data = 4'h7; tick();
    b1.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (b1.busy !== 1'b0 || b1.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_state: got busy=%0d rdy=%0d want 0 1", b1.busy, b1.in_ready); end
    checks++; if ({b1.alu_op, b1.alu_inC, b1.alu_inA, b1.alu_inB, b1.out_data} !== 16'h0 || b1.out_valid !== 1'b0 || b1.cmd_count !== 8'd0) begin errors++; $display("FAIL rstmid_outputs: got regs=%h ov=%0d cnt=%0d want 0000 0 0", {b1.alu_op, b1.alu_inC, b1.alu_inA, b1.alu_inB, b1.out_data}, b1.out_valid, b1.cmd_count); end
    b1.out_ready = 1'b1;
    send1(4'h4, 4'h2, 4'h9);
    checks++; if (b1.alu_op !== 2'd1 || b1.alu_inC !== 2'd0 || b1.alu_inA !== 4'h2 || b1.alu_inB !== 4'h9) begin errors++; $display("FAIL rstmid_operands: got op=%0d C=%0d A=%0h B=%0h want 1 0 2 9", b1.alu_op, b1.alu_inC, b1.alu_inA, b1.alu_inB); end
    tick();
    checks++; if (b1.out_valid !== 1'b1 || b1.out_data !== 4'hB) begin errors++; $display("FAIL rstmid_result: got ov=%0d data=%0h want 1 b", b1.out_valid, b1.out_data); end
    tick();
    checks++; if (b1.cmd_count !== 8'd1) begin errors++; $display("FAIL rstmid_count: got %0d want 1", b1.cmd_count); end
    b1.out_ready = 1'b0;
  endtask

  task automatic test_settle3();
    logic [3:0] a, bb, exp_d;
    logic [1:0] exp_c;
    b3.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a     = 4'(i);
      bb    = 4'(i + 1);
      exp_d = 4'(2 * i + 1);
      exp_c = 2'(i + 1);
      send3(4'h8, a, bb);
      tick();
      checks++; if (b3.out_valid !== 1'b0) begin errors++; $display("FAIL s3_early1_%0d: got %0d want 0", i, b3.out_valid); end
      tick();
      checks++; if (b3.out_valid !== 1'b0) begin errors++; $display("FAIL s3_early2_%0d: got %0d want 0", i, b3.out_valid); end
      tick();
      checks++; if (b3.out_valid !== 1'b1 || b3.out_data !== exp_d) begin errors++; $display("FAIL s3_result_%0d: got ov=%0d data=%0h want 1 %0h", i, b3.out_valid, b3.out_data, exp_d); end
      tick();
      checks++; if (b3.cmd_count !== exp_c || b3.busy !== 1'b0) begin errors++; $display("FAIL s3_count_%0d: got cnt=%0d busy=%0d want %0d 0", i, b3.cmd_count, b3.busy, exp_c); end
    end
    b3.out_ready = 1'b0;
  endtask

  initial begin
    b1.in_valid = 1'b0; b1.in_data = 4'h0; b1.out_ready = 1'b0;
    b3.in_valid = 1'b0; b3.in_data = 4'h0; b3.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    test_settle3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream issue stage for the 4-bit combinational ALU (inA, inB, inC, op -> ans). It accepts a nibble-serial command stream over a valid/ready handshake and assembles header, A and B. It then drives the ALU operands from registers, waits a fixed settle time, and captures ans. The result goes out on a valid/ready output port, and the block counts completed commands.

Parameters:
SETTLE, 1, number of EXEC cycles the ALU inputs are held before ans is sampled (legal range 1..15).
CNT_W, 8, width of the completed-command counter.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  in_data holds a valid nibble.
in_data  input  4  command nibble: header, then A, then B.
in_ready  output  1  block accepts a nibble this cycle.
alu_inA  output  4  registered operand A to the ALU.
alu_inB  output  4  registered operand B to the ALU.
alu_inC  output  2  registered operand C to the ALU (header bits [1:0]).
alu_op  output  2  registered opcode to the ALU (header bits [3:2]).
alu_ans  input  4  combinational ALU result.
out_valid  output  1  out_data holds a captured result.
out_data  output  4  captured ALU result.
out_ready  input  1  consumer accepts the result.
busy  output  1  high in any state other than HDR.
cmd_count  output  CNT_W  completed commands, wraps modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, active-high) clears all state at the next rising edge.
  - State returns to HDR.
  - All registered outputs go to 0: alu_*, out_data, out_valid, cmd_count, and the internal header/A holding registers.
  - Reset overrides every other event, including reset arriving mid-command or during DONE. A partial command is discarded.
- States: HDR, GETA, GETB, EXEC, DONE.
- in_ready = 1 in HDR, GETA and GETB; 0 in EXEC and DONE. A nibble transfers on an edge where in_valid && in_ready.
- HDR: on transfer, latch the header; go to GETA.
- GETA: on transfer, latch A; go to GETB.
- GETB: on transfer, load all four ALU operand registers on the same edge: alu_op = hdr[3:2], alu_inC = hdr[1:0], alu_inA = A, alu_inB = in_data. Load the settle counter with SETTLE-1; go to EXEC.
- HDR, GETA, GETB without a transfer: stay in the same state; no register changes.
- EXEC: if the counter is 0, then on the edge set out_data <= alu_ans and out_valid <= 1, and go to DONE. Otherwise decrement the counter.
- DONE:
  - out_valid = 1; out_data is held stable.
  - On an edge with out_ready = 1: out_valid <= 0, cmd_count <= cmd_count + 1 (wraps), go to HDR.
  - Otherwise hold indefinitely.
- alu_* outputs hold their last values after DONE until the next GETB transfer. They are not cleared between commands.
- Latency: out_valid rises SETTLE cycles after the B-acceptance edge. The minimum command-to-command period is 3 + SETTLE + 1 cycles, with in_valid and out_ready held high.
- in_valid during EXEC or DONE is ignored, and no nibble is consumed. in_data is don't-care when in_valid = 0.
- out_ready outside DONE has no effect.
- busy = (state != HDR).

Test Plan:
(The bench stubs the ALU as alu_ans = (alu_inA + alu_inB) mod 16.)
- Basic, SETTLE=1: nibbles 4'b0110, 4'h3, 4'h5 on consecutive cycles; out_ready = 1. Required: on the B edge alu_op=1, alu_inC=2, alu_inA=3, alu_inB=5; one cycle later out_valid=1 and out_data=8; cmd_count 0->1 on the following edge.
- Overflow wrap: A=4'hF, B=4'h2 -> out_data=1. in_ready=0 throughout EXEC/DONE; a nibble 4'hA presented there is not consumed.
- Backpressure: out_ready held 0 for 5 cycles after out_valid. Required: out_valid and out_data=8 stay stable, state stays DONE, in_ready=0, cmd_count unchanged; then exactly one increment when out_ready=1.
- Bubbles: in_valid toggles 1,0,0,1,0,1. Required: exactly three nibbles consumed; in_ready stays 1 during gaps; operands match the transferred nibbles.
- Reset mid-command: reset asserted for 1 cycle after the A nibble. Required: next cycle state=HDR, busy=0, all outputs 0. A new full command then completes correctly.
- SETTLE=3, CNT_W=2: run 5 commands. Required: out_valid exactly 3 cycles after each B edge; cmd_count sequence 1,2,3,0,1.
